// File: rtl/vga_pkg.sv
// Shared VGA-side definitions: frame geometry, the RGB444 pixel type,
// the loader FSM states and the 4-bit sample clamp.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef logic [11:0] rgb444_t;

    typedef enum logic {
        LOAD    = 1'b0,
        PENDING = 1'b1
    } load_state_t;

    // Saturate a sign-extended sample into the 0..15 grayscale range.
    function automatic logic [3:0] clamp4(input logic signed [31:0] s);
        logic [3:0] r;
        if (s < 0)
            r = 4'd0;
        else if (s > 32'sd15)
            r = 4'd15;
        else
            r = s[3:0];
        return r;
    endfunction

endpackage

// File: rtl/frame_dbuf.sv
// Double-buffered N x 4 frame store: one write port into the back buffer,
// one registered read port from the front buffer selected by sel.
module frame_dbuf #(
    parameter int N  = 196,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          swap,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [3:0]    rdata,
    output logic          sel
);

    logic [3:0] mem0 [N];
    logic [3:0] mem1 [N];

    // sel=0 displays mem0 and writes mem1; writes never touch the front buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel   <= 1'b0;
            rdata <= 4'd0;
            for (int i = 0; i < N; i++) begin
                mem0[i] <= 4'd0;
                mem1[i] <= 4'd0;
            end
        end else begin
            if (swap)
                sel <= ~sel;
            if (we && sel)
                mem0[waddr] <= wdata;
            if (we && !sel)
                mem1[waddr] <= wdata;
            rdata <= sel ? mem1[raddr] : mem0[raddr];
        end
    end

endmodule

// File: rtl/pixel_grid_renderer.sv
// Streams a signed image into a double-buffered store and renders it as an
// upscaled grayscale window with a border; h/v to data latency is 2 cycles.
module pixel_grid_renderer
    import vga_pkg::*;
#(
    parameter int            GRID_W     = 14,
    parameter int            GRID_H     = 14,
    parameter int            SCALE      = 20,
    parameter int            X0         = 180,
    parameter int            Y0         = 100,
    parameter int            DATA_W     = 10,
    parameter int            BORDER_PX  = 5,
    parameter logic [11:0]   BG_RGB     = 12'hFFF,
    parameter logic [11:0]   BORDER_RGB = 12'hF00,
    parameter int            SWAP_LINE  = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              load_err,
    output logic              swap_pending,
    output logic [11:0]       data
);

    localparam int N     = GRID_W * GRID_H;
    localparam int AW    = $clog2(N);
    localparam int WIN_W = GRID_W * SCALE;
    localparam int WIN_H = GRID_H * SCALE;

    // Write handshake: a sample transfers on any cycle with wr_valid && wr_ready.
    load_state_t   state, state_n;
    logic [AW-1:0] cnt, cnt_n;
    logic          accept, swap, err_n;
    logic [3:0]    wr_val;
    logic signed [31:0] wr_ext;

    assign wr_ready     = rst_n && (state == LOAD);
    assign swap_pending = (state == PENDING);
    assign accept       = wr_valid && wr_ready;
    assign wr_ext       = {{(32-DATA_W){wr_data[DATA_W-1]}}, wr_data};
    assign wr_val       = clamp4(wr_ext);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD;
            cnt      <= '0;
            load_err <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            load_err <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        swap    = 1'b0;
        err_n   = 1'b0;
        case (state)
            LOAD: begin
                if (accept) begin
                    err_n = (cnt == AW'(N-1)) != wr_last;
                    if (cnt == AW'(N-1))
                        state_n = PENDING;
                    else
                        cnt_n = cnt + 1'b1;
                end
            end
            PENDING: begin
                if (v_cnt == 10'(SWAP_LINE) && h_cnt == 10'd0) begin
                    swap    = 1'b1;
                    cnt_n   = '0;
                    state_n = LOAD;
                end
            end
            default: state_n = LOAD;
        endcase
    end

    // Region classification and block address from the raster position.
    int            hx, vy;
    logic          in_win, in_brd;
    logic [AW-1:0] raddr;

    always_comb begin
        hx     = int'({22'd0, h_cnt});
        vy     = int'({22'd0, v_cnt});
        in_win = (hx >= X0) && (hx < X0 + WIN_W) && (vy >= Y0) && (vy < Y0 + WIN_H);
        in_brd = (hx >= X0 - BORDER_PX) && (hx < X0 + WIN_W + BORDER_PX) &&
                 (vy >= Y0 - BORDER_PX) && (vy < Y0 + WIN_H + BORDER_PX);
        raddr  = '0;
        if (in_win)
            raddr = AW'((hx - X0) / SCALE + GRID_W * ((vy - Y0) / SCALE));
    end

    logic [3:0] rdata;
    logic       sel;
    logic       win_q, brd_q;

    frame_dbuf #(.N(N), .AW(AW)) u_dbuf (
        .clk   (clk),
        .rst_n (rst_n),
        .swap  (swap),
        .we    (accept),
        .waddr (cnt),
        .wdata (wr_val),
        .raddr (raddr),
        .rdata (rdata),
        .sel   (sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= 1'b0;
            brd_q <= 1'b0;
            data  <= 12'h000;
        end else begin
            win_q <= in_win;
            brd_q <= in_brd;
            if (win_q)
                data <= {rdata, rdata, rdata};
            else if (brd_q)
                data <= BORDER_RGB;
            else
                data <= BG_RGB;
        end
    end

endmodule

// File: tb/tb_pixel_grid_renderer.sv
// Directed-plus-random bench for pixel_grid_renderer against an image-level
// reference model of the front/back buffers and the screen layout.
module tb_pixel_grid_renderer;

    localparam int N = 196;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  h_cnt = 10'd0;
    logic [9:0]  v_cnt = 10'd0;
    logic        wr_valid = 1'b0;
    logic        wr_last = 1'b0;
    logic [9:0]  wr_data = 10'd0;
    logic        wr_ready;
    logic        load_err;
    logic        swap_pending;
    logic [11:0] data;

    pixel_grid_renderer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .h_cnt        (h_cnt),
        .v_cnt        (v_cnt),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .wr_last      (wr_last),
        .load_err     (load_err),
        .swap_pending (swap_pending),
        .data         (data)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int miss = 0;
    int front_m [N];
    int back_m [N];
    int img [N];
    int wcnt = 0;
    bit pend_m = 1'b0;
    int err_pulses = 0;

    function automatic int clampm(input int s);
        if (s < 0) return 0;
        if (s > 15) return 15;
        return s;
    endfunction

    function automatic logic [11:0] exp_pix(input int h, input int v);
        logic [3:0] q;
        if (h >= 180 && h < 460 && v >= 100 && v < 380) begin
            q = 4'(front_m[(h - 180) / 20 + 14 * ((v - 100) / 20)]);
            return {q, q, q};
        end
        if (h >= 175 && h < 465 && v >= 95 && v < 385)
            return 12'hF00;
        return 12'hFFF;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input int s, input bit last);
        int guard;
        bit exp_err;
        logic [31:0] sv;
        guard = 0;
        while (wr_ready !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        chk("wr_ready_before_write", {11'd0, wr_ready}, 12'd1);
        sv       = 32'(s);
        wr_valid = 1'b1;
        wr_data  = sv[9:0];
        wr_last  = last;
        step();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        exp_err  = ((wcnt == N - 1) != last);
        back_m[wcnt] = clampm(s);
        if (wcnt == N - 1) pend_m = 1'b1;
        else wcnt++;
        chk("load_err", {11'd0, load_err}, {11'd0, exp_err});
        if (load_err === 1'b1) err_pulses++;
    endtask

    task automatic load_img(input int extra_last);
        for (int i = 0; i < N; i++)
            push(img[i], (i == N - 1) || (i == extra_last));
        chk("swap_pending_after_load", {11'd0, swap_pending}, 12'd1);
        chk("wr_ready_after_load", {11'd0, wr_ready}, 12'd0);
    endtask

    task automatic swap_cycle();
        h_cnt = 10'd0;
        v_cnt = 10'd480;
        step();
        if (pend_m) begin
            for (int i = 0; i < N; i++) front_m[i] = back_m[i];
            pend_m = 1'b0;
            wcnt   = 0;
        end
        v_cnt = 10'd0;
        chk("swap_pending_after_swap", {11'd0, swap_pending}, {11'd0, pend_m});
    endtask

    task automatic check_pix(input int h, input int v, input string tag);
        h_cnt = 10'(h);
        v_cnt = 10'(v);
        step();
        step();
        chk(tag, data, exp_pix(h, v));
    endtask

    task automatic check_rand_pix(input int count, input string tag);
        for (int i = 0; i < count; i++)
            check_pix($urandom_range(160, 480), $urandom_range(80, 400), tag);
    endtask

    task automatic rand_img();
        for (int i = 0; i < N; i++)
            img[i] = int'($urandom_range(0, 1023)) - 512;
        img[$urandom_range(0, N - 1)] = -512;
        img[$urandom_range(0, N - 1)] = 511;
        img[$urandom_range(0, N - 1)] = 15;
        img[$urandom_range(0, N - 1)] = 16;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            front_m[i] = 0;
            back_m[i]  = 0;
        end
        wcnt   = 0;
        pend_m = 1'b0;
    endtask

    initial begin
        model_reset();

        // Reset state
        #2;
        chk("reset_data", data, 12'h000);
        chk("reset_wr_ready", {11'd0, wr_ready}, 12'd0);
        chk("reset_swap_pending", {11'd0, swap_pending}, 12'd0);
        chk("reset_load_err", {11'd0, load_err}, 12'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("wr_ready_after_release", {11'd0, wr_ready}, 12'd1);
        check_pix(200, 200, "front_zero_after_reset");

        // Ramp image k%16, swap, then check first blocks
        for (int i = 0; i < N; i++) img[i] = i % 16;
        load_img(-1);
        check_pix(200, 100, "before_swap_still_old");
        swap_cycle();
        check_pix(180, 100, "ramp_px_180_100");
        check_pix(200, 100, "ramp_px_200_100");
        check_rand_pix(6, "ramp_random");

        // Clamp boundaries
        rand_img();
        img[0] = -5;
        img[1] = 300;
        img[2] = 7;
        load_img(-1);
        swap_cycle();
        check_pix(180, 100, "clamp_neg");
        check_pix(200, 100, "clamp_big");
        check_pix(220, 100, "clamp_mid");

        // Border, background and window edges
        check_pix(177, 200, "border_left");
        check_pix(170, 200, "background_left");
        check_pix(459, 379, "last_window_pixel");
        check_pix(460, 379, "border_right");
        check_pix(300, 97, "border_top");
        check_pix(300, 382, "border_bottom");
        check_pix(300, 385, "background_bottom");
        check_pix(174, 94, "background_corner");
        check_rand_pix(20, "random_layout");

        // Tear-free: stream B while A is displayed
        rand_img();
        load_img(-1);
        swap_cycle();
        rand_img();
        for (int i = 0; i < N; i++) begin
            push(img[i], i == N - 1);
            if (i % 16 == 0)
                check_rand_pix(1, "tear_during_load");
        end
        check_rand_pix(5, "tear_pending");
        swap_cycle();
        check_rand_pix(5, "tear_after_swap");

        // Early wr_last on sample 10
        for (int i = 0; i < N; i++) img[i] = 8 + (i % 8);
        err_pulses = 0;
        load_img(10);
        chk("load_err_pulse_count", 12'(err_pulses), 12'd1);
        swap_cycle();
        check_pix(180, 100, "after_early_last_first");
        check_rand_pix(4, "after_early_last_random");

        // Reset during sample 100
        rand_img();
        check_pix(200, 100, "before_reset_window");
        for (int i = 0; i < 100; i++) push(img[i], 1'b0);
        wr_valid = 1'b1;
        wr_data  = 10'd9;
        rst_n    = 1'b0;
        #1;
        chk("midload_reset_data", data, 12'h000);
        chk("midload_reset_pending", {11'd0, swap_pending}, 12'd0);
        chk("midload_reset_ready", {11'd0, wr_ready}, 12'd0);
        wr_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        model_reset();
        step();
        for (int i = 0; i < 50; i++) push(img[i], 1'b0);
        swap_cycle();
        check_pix(200, 100, "no_swap_partial");
        for (int i = 50; i < N; i++) push(img[i], i == N - 1);
        chk("pending_after_fresh_load", {11'd0, swap_pending}, 12'd1);
        swap_cycle();
        check_pix(200, 100, "fresh_load_px");
        check_rand_pix(6, "fresh_load_random");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
